// File: rtl/lc3b_types.sv
// Shared cache/memory types: line, beat, beat index and the burst adapter's
// FSM encoding.
package lc3b_types;
   localparam int BEATS_PER_LINE = 4;

   typedef logic [127:0] lc3b_line;
   typedef logic [31:0]  lc3b_beat;
   typedef logic [1:0]   lc3b_beat_idx;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RBURST,
      S_WBURST,
      S_DONE
   } pmem_state_e;
endpackage

// File: rtl/pmem_burst_adapter_line_buffer.sv
// 128-bit line register with beat-indexed write and read ports plus a
// full-line load port.
module line_buffer
   import lc3b_types::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  lc3b_beat_idx idx,
   input  lc3b_beat     beat_in,
   input  logic         line_load,
   input  lc3b_line     line_in,
   output lc3b_line     line_out,
   output lc3b_beat     beat_out
);
   lc3b_beat [BEATS_PER_LINE-1:0] r_line;

   // A full-line load wins over a beat write; the top never asserts both.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_line <= '0;
      else if (line_load)
         r_line <= line_in;
      else if (load)
         r_line[idx] <= beat_in;
   end

   assign line_out = r_line;
   assign beat_out = r_line[idx];
endmodule

// File: rtl/pmem_burst_adapter.sv
// Converts single 128-bit cache line requests into 4-beat 32-bit memory
// bursts: fills assemble a line, write-backs serialize a latched victim.
module pmem_burst_adapter
   import lc3b_types::*;
#(
   parameter int LINE_W = 128,
   parameter int BUS_W  = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [ADDR_W-1:0] pmem_address,
   input  logic [LINE_W-1:0] pmem_wdata,
   output logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BUS_W-1:0]  mem_wdata,
   input  logic [BUS_W-1:0]  mem_rdata,
   input  logic              mem_ready
);
   pmem_state_e       r_state, w_state_nxt;
   lc3b_beat_idx      r_beat, w_beat_nxt;
   logic [ADDR_W-5:0] r_addr;
   logic              w_addr_ld;
   logic              w_wb_ld;
   logic              w_fill_ld;
   lc3b_beat          w_unused_fill_beat;
   lc3b_line          w_unused_wb_line;
   logic [3:0]        w_unused_addr_lo;

   assign w_unused_addr_lo = pmem_address[3:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         if (w_addr_ld)
            r_addr <= pmem_address[ADDR_W-1:4];
      end
   end

   // Write-back takes priority over a fill when both are requested in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_addr_ld   = 1'b0;
      w_wb_ld     = 1'b0;
      w_fill_ld   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      pmem_resp   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (pmem_write) begin
               w_state_nxt = S_WBURST;
               w_beat_nxt  = '0;
               w_addr_ld   = 1'b1;
               w_wb_ld     = 1'b1;
            end else if (pmem_read) begin
               w_state_nxt = S_RBURST;
               w_beat_nxt  = '0;
               w_addr_ld   = 1'b1;
            end
         end
         S_RBURST: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               w_fill_ld  = 1'b1;
               w_beat_nxt = r_beat + 2'd1;
               if (r_beat == 2'd3)
                  w_state_nxt = S_DONE;
            end
         end
         S_WBURST: begin
            mem_write = 1'b1;
            if (mem_ready) begin
               w_beat_nxt = r_beat + 2'd1;
               if (r_beat == 2'd3)
                  w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            pmem_resp   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   line_buffer u_fill (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (w_fill_ld),
      .idx       (r_beat),
      .beat_in   (mem_rdata),
      .line_load (1'b0),
      .line_in   ('0),
      .line_out  (pmem_rdata),
      .beat_out  (w_unused_fill_beat)
   );

   line_buffer u_wb (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (1'b0),
      .idx       (r_beat),
      .beat_in   ('0),
      .line_load (w_wb_ld),
      .line_in   (pmem_wdata),
      .line_out  (w_unused_wb_line),
      .beat_out  (mem_wdata)
   );

   assign mem_address = {r_addr, 4'h0};
endmodule
